fifo_stream_reader: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/fifo_out_buf.sv | 67 ++++++
 rtl/fifo_stream_reader.sv | 143 ++++++++++++++
 tb/tb_fifo_stream_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream consumer.
package fifo_rd_pkg;

    localparam int DATA_LENGTH_DEF = 32;
    localparam int CNT_W           = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_out_buf.sv
// Small synchronous ring buffer that absorbs samples returning from the FIFO
// and presents the oldest one at its head.
module fifo_out_buf
    import fifo_rd_pkg::*;
#(
    parameter  int DATA_LENGTH = DATA_LENGTH_DEF,
    parameter  int BUF_DEPTH   = 2,
    localparam int PTR_W       = $clog2(BUF_DEPTH),
    localparam int OCC_W       = $clog2(BUF_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DATA_LENGTH-1:0] push_data,
    input  logic                   pop,
    output logic [OCC_W-1:0]       occ,
    output logic [DATA_LENGTH-1:0] head_data
);

    logic [DATA_LENGTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [OCC_W-1:0]       r_occ;
    logic                   w_wr;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_wr = push & ~flush;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({push, pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occ       = r_occ;
    assign head_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the dual-clock sample FIFO: issues reads, absorbs the
// one-cycle read latency and streams samples with frame markers downstream.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter  int DATA_LENGTH = DATA_LENGTH_DEF,
    parameter  int BUF_DEPTH   = 2,
    parameter  int FRAME_LEN   = 64,
    localparam int FIDX_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                   rd_clk,
    input  logic                   rst_fifo_n,
    input  logic                   en,
    input  logic                   flush,
    output logic                   fifo_rd_en,
    input  logic [DATA_LENGTH-1:0] fifo_data,
    input  logic                   fifo_empty,
    input  logic                   fifo_underflow,
    output logic [DATA_LENGTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   underflow_err,
    output logic [CNT_W-1:0]       sample_count,
    output state_t                 dbg_state,
    output logic [FIDX_W-1:0]      dbg_frame_idx
);

    // Stream handshake: a sample transfers in any cycle where m_valid and
    // m_ready are both high; m_valid/m_data/m_last hold until that transfer.
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W = $clog2(BUF_DEPTH + 2) + 1;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_inflight;
    logic [FIDX_W-1:0]      r_frame_idx;
    logic [CNT_W-1:0]       r_sample_count;
    logic                   r_underflow_err;
    logic [OCC_W-1:0]       w_occ;
    logic [DATA_LENGTH-1:0] w_head;
    logic                   w_m_valid;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_room;
    logic                   w_rd_en;
    logic                   w_busy;
    logic                   w_frame_end;

    assign w_m_valid   = (w_occ != '0);
    assign w_pop       = w_m_valid & m_ready;
    assign w_push      = r_inflight & ~flush;
    assign w_frame_end = (r_frame_idx == FIDX_W'(FRAME_LEN - 1));
    // occ + inflight - pop < BUF_DEPTH, rearranged to stay unsigned.
    assign w_room = (SUM_W'(w_occ) + SUM_W'(r_inflight)) <
                    (SUM_W'(BUF_DEPTH) + SUM_W'(w_pop));

    fifo_out_buf #(
        .DATA_LENGTH (DATA_LENGTH),
        .BUF_DEPTH   (BUF_DEPTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst_n     (rst_fifo_n),
        .flush     (flush),
        .push      (w_push),
        .push_data (fifo_data),
        .pop       (w_pop),
        .occ       (w_occ),
        .head_data (w_head)
    );

    always_ff @(posedge rd_clk or negedge rst_fifo_n) begin
        if (!rst_fifo_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = en ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE:    if (en) w_next_state = RUN;
                RUN:     if (!en) w_next_state = DRAIN;
                DRAIN: begin
                    if (en) begin
                        w_next_state = RUN;
                    end else if (!r_inflight && (w_occ == '0)) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_en = 1'b0;
        w_busy  = (r_state != IDLE);
        if ((r_state == RUN) && en && !fifo_empty && !flush && w_room) begin
            w_rd_en = 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rst_fifo_n) begin
        if (!rst_fifo_n) begin
            r_inflight      <= 1'b0;
            r_frame_idx     <= '0;
            r_sample_count  <= '0;
            r_underflow_err <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (flush) begin
                r_frame_idx     <= '0;
                r_sample_count  <= '0;
                r_underflow_err <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_frame_idx    <= w_frame_end ? '0 : r_frame_idx + 1'b1;
                    r_sample_count <= r_sample_count + 1'b1;
                end
                if (w_rd_en && fifo_underflow) begin
                    r_underflow_err <= 1'b1;
                end
            end
        end
    end

    assign fifo_rd_en    = w_rd_en;
    assign m_valid       = w_m_valid;
    assign m_data        = w_m_valid ? w_head : '0;
    assign m_last        = w_frame_end & w_m_valid;
    assign busy          = w_busy;
    assign underflow_err = r_underflow_err;
    assign sample_count  = r_sample_count;
    assign dbg_state     = r_state;
    assign dbg_frame_idx = r_frame_idx;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + randomized bench for fifo_stream_reader with a behavioural FIFO
// and a scoreboard of words read from that FIFO.
module tb_fifo_stream_reader;
    import fifo_rd_pkg::*;

    localparam int DW        = 32;
    localparam int FRAME_LEN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty;
    logic          fifo_underflow = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          busy;
    logic          underflow_err;
    logic [31:0]   sample_count;
    state_t        dbg_state;
    logic [1:0]    dbg_frame_idx;

    fifo_stream_reader #(
        .DATA_LENGTH (DW),
        .BUF_DEPTH   (2),
        .FRAME_LEN   (FRAME_LEN)
    ) dut (
        .rd_clk         (clk),
        .rst_fifo_n     (rst_n),
        .en             (en),
        .flush          (flush),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .busy           (busy),
        .underflow_err  (underflow_err),
        .sample_count   (sample_count),
        .dbg_state      (dbg_state),
        .dbg_frame_idx  (dbg_frame_idx)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural FIFO: words are written by the stimulus, read with one cycle latency
    logic [DW-1:0] fifo_mem [0:1023];
    int            wr_n = 0;
    int            rd_n = 0;
    assign fifo_empty = (rd_n == wr_n);

    // scoreboard state
    logic [DW-1:0] exp_q[$];
    int            model_cnt = 0;
    int            n_last = 0;
    logic [DW-1:0] last_data = '0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          hold_last = 1'b0;
    logic [DW-1:0] rd_word;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [DW-1:0] w);
        fifo_mem[wr_n] = w;
        wr_n++;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rd_n == wr_n && exp_q.size() == 0 && !m_valid) break;
        end
        chk(tag, 32'(rd_n == wr_n && exp_q.size() == 0 && !m_valid), 1);
    endtask

    // FIFO read side and scoreboard bookkeeping at the active edge
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (flush) begin
                exp_q.delete();
                model_cnt = 0;
            end
            if (fifo_rd_en) begin
                rd_word = (rd_n < wr_n) ? fifo_mem[rd_n] : 32'hDEAD_BEEF;
                rd_n      <= rd_n + 1;
                fifo_data <= rd_word;
                exp_q.push_back(rd_word);
            end
        end
    end

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
            chk("sample_count", sample_count, model_cnt);
            chk("frame_idx", 32'(dbg_frame_idx), model_cnt % FRAME_LEN);
            if (!m_valid) chk("last_without_valid", 32'(m_last), 0);
            if (hold_prev) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_data", m_data, hold_data);
                chk("hold_last", 32'(m_last), 32'(hold_last));
            end
            if (m_valid && m_ready) begin
                chk("sample_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("m_data", m_data, exp_q.pop_front());
                end
                chk("m_last", 32'(m_last), 32'((model_cnt % FRAME_LEN) == FRAME_LEN - 1));
                if (m_last) n_last++;
                last_data = m_data;
                model_cnt++;
            end
            hold_prev = m_valid & ~m_ready & ~flush;
            hold_data = m_data;
            hold_last = m_last;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        int base;

        // reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underflow", 32'(underflow_err), 0);
        chk("rst_count", sample_count, 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_frame_idx", 32'(dbg_frame_idx), 0);
        repeat (3) step();
        rst_n = 1'b1;

        // steady stream of 0x00..0x0F
        for (int i = 0; i < 16; i++) fifo_push(32'(i));
        step();
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en) break;
        end
        chk("first_rd_en", 32'(fifo_rd_en), 1);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (m_valid) break;
        end
        chk("first_latency", lat, 2);
        cnt = 0;
        for (int j = 0; j < 16; j++) begin
            if (m_valid && m_ready) cnt++;
            @(negedge clk);
        end
        chk("throughput", cnt, 16);
        chk("steady_count", sample_count, 16);

        // backpressure mid-stream
        step();
        for (int i = 0; i < 10; i++) fifo_push($urandom);
        repeat (3) @(negedge clk);
        step();
        m_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_rd_en_stopped", 32'(fifo_rd_en), 0);
        chk("bp_valid_held", 32'(m_valid), 1);
        step();
        m_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_count", sample_count, 26);

        // random backpressure
        step();
        for (int i = 0; i < 40; i++) fifo_push($urandom);
        for (int i = 0; i < 120; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        m_ready = 1'b1;
        wait_drain("rand_drain");
        chk("rand_count", sample_count, 66);

        // empty FIFO, then a single word
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("empty_no_read", 32'(fifo_rd_en), 0);
        end
        step();
        fifo_push(32'hA5A5_A5A5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sample_count == 67) break;
        end
        chk("single_count", sample_count, 67);
        chk("single_data", last_data, 32'hA5A5_A5A5);
        chk("single_no_underflow", 32'(underflow_err), 0);

        // frames of 4: flush first so counters restart
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_count", sample_count, 0);
        chk("flush_frame_idx", 32'(dbg_frame_idx), 0);
        base = n_last;
        step();
        for (int i = 0; i < 9; i++) fifo_push($urandom);
        wait_drain("frame_drain");
        chk("frame_count", sample_count, 9);
        chk("frame_idx_end", 32'(dbg_frame_idx), 1);
        chk("frame_last_marks", n_last - base, 2);

        // drop en with a read in flight
        step();
        for (int i = 0; i < 8; i++) fifo_push($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en) break;
        end
        chk("drain_rd_seen", 32'(fifo_rd_en), 1);
        step();
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_rd_en) cnt++;
            if (!busy) break;
        end
        chk("drain_idle", 32'(busy), 0);
        chk("drain_state", 32'(dbg_state), 32'(IDLE));
        chk("drain_no_reads", cnt, 0);
        chk("drain_delivered", exp_q.size(), 0);

        // flush with a full buffer
        step();
        en = 1'b1;
        m_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("full_valid", 32'(m_valid), 1);
        chk("full_no_read", 32'(fifo_rd_en), 0);
        step();
        flush = 1'b1;
        en = 1'b0;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(m_valid), 0);
        chk("flush_count2", sample_count, 0);
        chk("flush_frame2", 32'(dbg_frame_idx), 0);
        chk("flush_idle", 32'(busy), 0);

        // underflow flag without a read must not set the error
        step();
        m_ready = 1'b1;
        fifo_underflow = 1'b1;
        repeat (3) @(negedge clk);
        chk("uf_no_read", 32'(underflow_err), 0);
        step();
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en) break;
        end
        chk("uf_rd_seen", 32'(fifo_rd_en), 1);
        step();
        fifo_underflow = 1'b0;
        @(negedge clk);
        chk("uf_set", 32'(underflow_err), 1);
        step();
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("uf_sticky", 32'(underflow_err), 1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("uf_cleared", 32'(underflow_err), 0);

        // reset asserted mid-stream
        step();
        for (int i = 0; i < 20; i++) fifo_push($urandom);
        en = 1'b1;
        repeat (6) @(negedge clk);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_last", 32'(m_last), 0);
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_count", sample_count, 0);
        chk("mid_rst_frame", 32'(dbg_frame_idx), 0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_drain("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
